// File: rtl/serial_receive.sv
// rtl/serial_receive.sv - RS-232 8N1 receiver with byte FIFO and 4-phase command/response handshake
// Optional stop-bit check and break handling: define SERIAL_RECEIVE_FRAMING_CHECK_EN.
module serial_receive #(
  parameter logic [31:0] CLOCK_RATE      = 32'd50000000,
  parameter logic [31:0] BAUD            = 32'd113500,
  parameter int          FIFO_DEPTH_LOG2 = 2
) (
  input  logic       OSC_50,
  input  logic       reset_50m,
  input  logic       clock_valid,
  input  logic       UART_RXD,
  input  logic       serial_receive_command,
  output logic       serial_receive_response,
  output logic [7:0] serial_receive_data,
  output logic       serial_receive_overrun,
  output logic       serial_receive_framing_error
);

  localparam logic [31:0] BIT_CYCLES = CLOCK_RATE / BAUD;
  localparam logic [31:0] HALF_BIT   = BIT_CYCLES >> 1;
  localparam int          DEPTH      = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FIFO_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_STORE = 3'd4;
`ifdef SERIAL_RECEIVE_FRAMING_CHECK_EN
  localparam logic [2:0] RX_BREAK = 3'd5;
`endif

  localparam logic [0:0] HS_WAIT = 1'b0;
  localparam logic [0:0] HS_ACK  = 1'b1;

  logic                       sync1;
  logic                       rxs;
  logic [2:0]                 rx_state;
  logic [31:0]                timer;
  logic [3:0]                 bit_cnt;
  logic [7:0]                 shift;
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic [0:0]                 hs_state;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       frame_ok;
  logic                       push;
  logic                       pop;

  assign fifo_full  = (count == FIFO_FULL);
  assign fifo_empty = (count == '0);

`ifdef SERIAL_RECEIVE_FRAMING_CHECK_EN
  logic stop_bit;
  assign frame_ok = stop_bit;
`else
  assign frame_ok = 1'b1;
  assign serial_receive_framing_error = 1'b0;
`endif

  assign push = clock_valid && (rx_state == RX_STORE) && frame_ok && !fifo_full;
  // The ack state is only entered with a non-empty FIFO, so a pop here never underflows.
  assign pop  = clock_valid && (hs_state == HS_ACK) && !serial_receive_command;
  assign serial_receive_response = (hs_state == HS_ACK);

  // Bit periods reload with BIT_CYCLES-1 because the zero count is itself a cycle;
  // this keeps samples at exact N.5 bit times instead of drifting a cycle per bit.
  always_ff @(posedge OSC_50 or posedge reset_50m) begin
    if (reset_50m) begin
      sync1                  <= 1'b1;
      rxs                    <= 1'b1;
      rx_state               <= RX_IDLE;
      timer                  <= HALF_BIT;
      bit_cnt                <= 4'd0;
      shift                  <= 8'h00;
      serial_receive_overrun <= 1'b0;
`ifdef SERIAL_RECEIVE_FRAMING_CHECK_EN
      stop_bit                     <= 1'b1;
      serial_receive_framing_error <= 1'b0;
`endif
    end else if (clock_valid) begin
      sync1 <= UART_RXD;
      rxs   <= sync1;
      case (rx_state)
        RX_IDLE: begin
          timer <= HALF_BIT;
          if (!rxs) rx_state <= RX_START;
        end
        RX_START: begin
          if (timer != '0) begin
            timer <= timer - 32'd1;
          end else if (!rxs) begin
            rx_state <= RX_DATA;
            timer    <= BIT_CYCLES - 32'd1;
            bit_cnt  <= 4'd8;
          end else begin
            rx_state <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (timer != '0) begin
            timer <= timer - 32'd1;
          end else begin
            shift   <= {rxs, shift[7:1]};
            bit_cnt <= bit_cnt - 4'd1;
            timer   <= BIT_CYCLES - 32'd1;
            if (bit_cnt == 4'd1) rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (timer != '0) begin
            timer <= timer - 32'd1;
          end else begin
`ifdef SERIAL_RECEIVE_FRAMING_CHECK_EN
            stop_bit <= rxs;
`endif
            rx_state <= RX_STORE;
          end
        end
        RX_STORE: begin
`ifdef SERIAL_RECEIVE_FRAMING_CHECK_EN
          if (!stop_bit) begin
            serial_receive_framing_error <= 1'b1;
            rx_state                     <= RX_BREAK;
          end else begin
            if (fifo_full) serial_receive_overrun <= 1'b1;
            rx_state <= RX_IDLE;
          end
`else
          if (fifo_full) serial_receive_overrun <= 1'b1;
          rx_state <= RX_IDLE;
`endif
        end
`ifdef SERIAL_RECEIVE_FRAMING_CHECK_EN
        // Hold off until the line returns high so a break is not seen as a new start bit.
        RX_BREAK: begin
          if (rxs) rx_state <= RX_IDLE;
        end
`endif
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge OSC_50) begin
    if (push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge OSC_50 or posedge reset_50m) begin
    if (reset_50m) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clock_valid) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge OSC_50 or posedge reset_50m) begin
    if (reset_50m) begin
      hs_state            <= HS_WAIT;
      serial_receive_data <= 8'h00;
    end else if (clock_valid) begin
      if (hs_state == HS_WAIT) begin
        if (serial_receive_command && !fifo_empty) begin
          serial_receive_data <= mem[rd_ptr];
          hs_state            <= HS_ACK;
        end
      end else if (!serial_receive_command) begin
        hs_state <= HS_WAIT;
      end
    end
  end

endmodule

// File: tb/tb_serial_receive.sv
// tb/tb_serial_receive.sv - scoreboard bench for serial_receive with a queue-based receive model
module tb_serial_receive;

  localparam int BIT        = 440;
  localparam int FIFO_DEPTH = 4;

  logic       OSC_50 = 1'b0;
  logic       reset_50m;
  logic       clock_valid;
  logic       UART_RXD;
  logic       serial_receive_command;
  logic       serial_receive_response;
  logic [7:0] serial_receive_data;
  logic       serial_receive_overrun;
  logic       serial_receive_framing_error;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int resp_cycle = 0;
  int frame_start = 0;
  int lat_lo, lat_hi, latency;

  logic [7:0] model_fifo[$];
  logic [7:0] exp_q[$];
  logic       model_overrun = 1'b0;
  logic       model_ferr = 1'b0;

  serial_receive dut (
    .OSC_50                       (OSC_50),
    .reset_50m                    (reset_50m),
    .clock_valid                  (clock_valid),
    .UART_RXD                     (UART_RXD),
    .serial_receive_command       (serial_receive_command),
    .serial_receive_response      (serial_receive_response),
    .serial_receive_data          (serial_receive_data),
    .serial_receive_overrun       (serial_receive_overrun),
    .serial_receive_framing_error (serial_receive_framing_error)
  );

  always #10 OSC_50 = ~OSC_50;
  always @(posedge OSC_50) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rising response is matched against the next expected byte.
  logic       resp_d = 1'b0;
  logic [7:0] held = 8'h00;
  logic [7:0] exp_byte;
  always @(negedge OSC_50) begin
    if (serial_receive_response && !resp_d) begin
      resp_cycle = cycle;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response: got data 0x%0h, want no response", serial_receive_data);
      end else begin
        exp_byte = exp_q.pop_front();
        check("rx_data", serial_receive_data, exp_byte);
      end
      held = serial_receive_data;
    end else if (serial_receive_response) begin
      check("data_stable", serial_receive_data, held);
    end
    resp_d = serial_receive_response;
  end

  task automatic model_push(input logic [7:0] b);
    if (model_fifo.size() < FIFO_DEPTH) model_fifo.push_back(b);
    else model_overrun = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      UART_RXD = f[i];
      repeat (BIT) @(negedge OSC_50);
    end
    UART_RXD = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
    model_push(b);
  endtask

  task automatic cpu_read();
    bit expect_resp;
    bit got;
    int window;
    expect_resp = (model_fifo.size() > 0);
    if (expect_resp) exp_q.push_back(model_fifo.pop_front());
    window = expect_resp ? 2 : 20;
    got = 1'b0;
    serial_receive_command = 1'b1;
    for (int i = 0; i < window && !got; i++) begin
      @(negedge OSC_50);
      got = serial_receive_response;
    end
    check("read_response", 32'(got), 32'(expect_resp));
    if (!got) exp_q.delete();
    serial_receive_command = 1'b0;
    @(negedge OSC_50);
    check("response_release", 32'(serial_receive_response), 32'd0);
    repeat (2) @(negedge OSC_50);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_response"}, 32'(serial_receive_response), 32'd0);
    check({tag, "_data"}, 32'(serial_receive_data), 32'd0);
    check({tag, "_overrun"}, 32'(serial_receive_overrun), 32'd0);
    check({tag, "_framing"}, 32'(serial_receive_framing_error), 32'd0);
  endtask

  task automatic clear_model();
    model_fifo.delete();
    exp_q.delete();
    model_overrun = 1'b0;
    model_ferr = 1'b0;
  endtask

  initial begin
    repeat (120000) @(posedge OSC_50);
    $display("FAIL watchdog: got %0d cycles, want completion", cycle);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] part;
    int n, r;
    reset_50m = 1'b1;
    clock_valid = 1'b1;
    UART_RXD = 1'b1;
    serial_receive_command = 1'b0;
    repeat (3) @(negedge OSC_50);
    check_reset_outputs("reset");
    reset_50m = 1'b0;
    repeat (5) @(negedge OSC_50);

    // 0x55, a frozen clock_valid window, then a normal read and an empty read.
    send_byte(8'h55);
    clock_valid = 1'b0;
    serial_receive_command = 1'b1;
    repeat (5) @(negedge OSC_50);
    check("hold_when_clock_invalid", 32'(serial_receive_response), 32'd0);
    serial_receive_command = 1'b0;
    @(negedge OSC_50);
    clock_valid = 1'b1;
    cpu_read();
    cpu_read();

    // Short low glitch must not produce a byte.
    UART_RXD = 1'b0;
    repeat (100) @(negedge OSC_50);
    UART_RXD = 1'b1;
    repeat (BIT) @(negedge OSC_50);
    cpu_read();

    for (int it = 0; it < 2; it++) begin
      n = $urandom_range(1, 2);
      for (int k = 0; k < n; k++) send_byte(8'($urandom));
      check("random_overrun", 32'(serial_receive_overrun), 32'(model_overrun));
      r = $urandom_range(0, n + 1);
      repeat (r) cpu_read();
    end
    repeat (model_fifo.size()) cpu_read();

    // Five back-to-back frames into a four-entry FIFO.
    send_byte(8'hA3);
    send_byte(8'h0F);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h81);
    check("overrun_after_fifth", 32'(serial_receive_overrun), 32'(model_overrun));
    repeat (5) cpu_read();

    // Command held on an empty FIFO; response follows the stop-bit sample.
    exp_q.push_back(8'h3C);
    serial_receive_command = 1'b1;
    resp_cycle = 0;
    frame_start = cycle;
    send_frame(8'h3C, 1'b1);
    check("held_cmd_response", 32'(serial_receive_response), 32'd1);
    lat_lo = (BIT * 19) / 2 + 2;
    lat_hi = lat_lo + 7;
    latency = resp_cycle - frame_start;
    checks++;
    if (latency < lat_lo || latency > lat_hi) begin
      errors++;
      $display("FAIL held_cmd_latency: got %0d cycles, want %0d..%0d", latency, lat_lo, lat_hi);
    end
    serial_receive_command = 1'b0;
    @(negedge OSC_50);
    check("held_cmd_release", 32'(serial_receive_response), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge OSC_50);

    // Stop bit sampled low, then a good frame.
    send_frame(8'h42, 1'b0);
    repeat (2 * BIT) @(negedge OSC_50);
`ifdef SERIAL_RECEIVE_FRAMING_CHECK_EN
    model_ferr = 1'b1;
`else
    model_push(8'h42);
`endif
    check("framing_error", 32'(serial_receive_framing_error), 32'(model_ferr));
    send_byte(8'h24);
    repeat (model_fifo.size() + 1) cpu_read();

    // Reset in the middle of a frame.
    part = {8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) begin
      UART_RXD = part[i];
      repeat (BIT) @(negedge OSC_50);
    end
    UART_RXD = part[5];
    repeat (BIT / 2) @(negedge OSC_50);
    reset_50m = 1'b1;
    #1;
    check_reset_outputs("reset_mid_frame");
    clear_model();
    UART_RXD = 1'b1;
    repeat (2) @(negedge OSC_50);
    reset_50m = 1'b0;
    repeat (2) @(negedge OSC_50);

    // Reset while the response is high.
    send_byte(8'h66);
    exp_q.push_back(model_fifo.pop_front());
    serial_receive_command = 1'b1;
    repeat (2) @(negedge OSC_50);
    check("resp_before_reset", 32'(serial_receive_response), 32'd1);
    reset_50m = 1'b1;
    #1;
    check_reset_outputs("reset_mid_handshake");
    serial_receive_command = 1'b0;
    clear_model();
    @(negedge OSC_50);
    reset_50m = 1'b0;
    repeat (2) @(negedge OSC_50);

    send_byte(8'h99);
    cpu_read();
    cpu_read();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
